instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the instruction-memory read interface: owns the PC, drives imem_addr,
//  waits a fixed read latency, captures imem_data and offers it to decode with valid/ready.
//  Supports branch redirect and halts on the all-zero word (unprogrammed/end of program).
//  Sits between the PC/branch logic and decode in the NesProcessor datapath.
// PARAMETERS
//  RESET_PC      64'h0  PC loaded on reset; first fetch address
//  READ_LATENCY  2      clocks from imem_addr stable to imem_data sampled; legal range >= 1
//  HALT_ON_ZERO  1      1: captured 32'h00000000 enters HALT; 0: issued as a normal word
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  imem_addr       out  64  fetch address to instruction memory; equals pc in FETCH
//  imem_data       in   32  instruction word returned by memory
//  instr_out       out  32  captured instruction; stable while instr_valid
//  instr_pc        out  64  address instr_out was fetched from
//  instr_valid     out  1   instr_out/instr_pc valid for decode
//  instr_ready     in   1   decode accepts; handshake = instr_valid & instr_ready
//  redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   64  redirect target; bits [1:0] ignored (forced to 0)
//  halted          out  1   high in HALT
//  fetch_count     out  32  count of handshakes; wraps mod 2^32
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, cnt=0, instr_valid=0, halted=0,
//   instr_out=0, instr_pc=0, fetch_count=0, imem_addr=RESET_PC. Outputs change immediately.
//  States: FETCH, ISSUE, HALT. imem_addr = pc in all states (registered pc).
//  FETCH: cnt increments each clk; on the edge with cnt==READ_LATENCY-1: instr_out<=imem_data,
//   instr_pc<=pc, cnt<=0; if HALT_ON_ZERO && imem_data==0 -> HALT, else -> ISSUE, instr_valid<=1.
//   => instr_valid rises READ_LATENCY edges after entering FETCH.
//  ISSUE: instr_valid held, instr_out/instr_pc frozen until handshake. On handshake:
//   fetch_count+=1, pc<=pc+4 (64-bit, wraps mod 2^64), instr_valid<=0, -> FETCH.
//   Throughput with instr_ready=1: one instruction per READ_LATENCY+1 clocks.
//  HALT: instr_valid=0, halted=1, pc frozen at the zero-word address; only redirect or reset exits.
//  Redirect (priority over all transitions, any state): pc<={redirect_pc[63:2],2'b00}, cnt<=0,
//   instr_valid<=0, halted<=0, -> FETCH. In-flight fetch discarded, never issued.
//  Redirect + handshake same edge: handshake counts (fetch_count+=1); pc takes redirect target.
//  instr_ready while instr_valid=0: ignored. redirect_valid held >1 cycle: each cycle restarts FETCH.
//  Reset mid-FETCH/ISSUE/HALT: all state discarded, resumes at RESET_PC after rst_n rises.
// TESTING  (memory model = program ROM image, READ_LATENCY=2, instr_ready=1 unless stated)
//  1 Release reset -> valid at 2nd edge: (0x000,F84003E9), then (0x004,F84083EA),(0x008,F84103EB)
//    every 3 clocks; fetch_count=3 after third handshake.
//  2 Hold instr_ready=0 for 10 clocks at pc 0x014 -> instr_out=AA0B014A, instr_pc=0x014 stable,
//    fetch_count unchanged; release -> next word 8A0A018C at 0x018.
//  3 redirect_valid pulse, redirect_pc=0x035, mid-FETCH of 0x020 -> 0x020 word never issued;
//    next issued (0x034, D2E24689).
//  4 Run sequentially to 0x058 (imem_data=0) -> halted=1, instr_valid=0, imem_addr=0x058 held;
//    redirect to 0x000 -> halted=0, next issued (0x000,F84003E9).
//  5 Redirect to 0x02C on same edge as handshake of 0x028 -> fetch_count increments,
//    next issued (0x02C, F80203ED).
//  6 Assert rst_n=0 asynchronously while instr_valid=1 -> instr_valid, halted, fetch_count = 0
//    before next edge; imem_addr=0x000; after release test 1 sequence repeats.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch requester: owns the PC, drives imem_addr, captures imem_data and offers it to decode.
// Latency: instr_valid rises READ_LATENCY clocks after entering FETCH; one word per READ_LATENCY+1 clocks.
// Backpressure: a word is held in ISSUE until instr_valid & instr_ready; redirect overrides everything.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          READ_LATENCY = 2,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    // Wide enough to hold READ_LATENCY-1; at least one bit so latency 1 still has a counter.
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [63:0]   r_pc;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_instr_out;
    logic [63:0]   r_instr_pc;
    logic          r_instr_valid;
    logic          r_halted;
    logic [31:0]   r_fetch_count;

    logic          w_handshake;
    logic          w_capture;
    logic          w_zero_word;

    // instr_valid is only ever high in ISSUE, so ready while idle is naturally ignored.
    assign w_handshake = r_instr_valid & instr_ready;
    assign w_capture   = (r_state == S_FETCH) && (r_cnt == LAST_CNT);
    assign w_zero_word = HALT_ON_ZERO && (imem_data == 32'h0);

    assign imem_addr   = r_pc;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

    // Fetch FSM: latency counting, capture, issue handshake, halt and redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_cnt         <= '0;
            r_instr_out   <= 32'h0;
            r_instr_pc    <= 64'h0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            // A handshake on the redirect edge still counts: decode has consumed the word.
            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                // Any in-flight fetch is dropped; the target is forced word-aligned.
                r_pc          <= {redirect_pc[63:2], 2'b00};
                r_cnt         <= '0;
                r_instr_valid <= 1'b0;
                r_halted      <= 1'b0;
                r_state       <= S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_capture) begin
                            r_instr_out <= imem_data;
                            r_instr_pc  <= r_pc;
                            r_cnt       <= '0;
                            if (w_zero_word) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_instr_valid <= 1'b1;
                                r_state       <= S_ISSUE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (w_handshake) begin
                            r_pc          <= r_pc + 64'd4;
                            r_instr_valid <= 1'b0;
                            r_state       <= S_FETCH;
                        end
                    end
                    S_HALT: begin
                        // PC stays on the zero word until a redirect or reset.
                    end
                    default: begin
                        r_state <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule
